// File: rtl/ram_stream_loader_pkg.sv
// Shared constants and FSM encoding for the RAM512 stream loader.
// RAM512 geometry is used by RAM512, the CPU and this loader.
// State encoding is shared so the bench and debug tooling can decode it.
package ram_stream_loader_pkg;

  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/ram_stream_loader_if.sv
// Stream input plus RAM512 write/read port bundle for the loader.
// master: the loader side (takes stream words, drives the RAM port).
// slave: the environment side (stream source and the RAM itself).
interface ram_stream_loader_if
  import ram_stream_loader_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;

  modport master (
    input  s_valid, s_data, ram_out,
    output s_ready, ram_load, ram_address, ram_in
  );

  modport slave (
    output s_valid, s_data, ram_out,
    input  s_ready, ram_load, ram_address, ram_in
  );

endinterface

// File: rtl/ram_stream_loader.sv
// Writes a valid/ready word stream into consecutive RAM512 addresses from a base.
// Latency: 2 cycles per word (accept, write), 3 with RAM_VERIFY_EN read-back check.
// Backpressure: s_ready only in the accept state; upstream gaps simply hold the FSM there.
module ram_stream_loader
  import ram_stream_loader_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  ram_stream_loader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                verify_err
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [ADDR_W:0]   remaining, remaining_d;
  logic [ADDR_W-1:0] ram_address_d;
  logic [DATA_W-1:0] ram_in_d;
  logic              s_ready_d, ram_load_d, busy_d, done_d;

`ifdef RAM_VERIFY_EN
  logic verify_err_q, verify_err_d;
  assign verify_err = verify_err_q;
`else
  // Without read-back the RAM output is never looked at.
  logic unused_ram_out;
  assign unused_ram_out = ^bus.ram_out;
  assign verify_err     = 1'b0;
`endif

  // Next-state and next-output decode; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d       = state;
    addr_d        = addr;
    remaining_d   = remaining;
    ram_address_d = bus.ram_address;
    ram_in_d      = bus.ram_in;
`ifdef RAM_VERIFY_EN
    verify_err_d  = verify_err_q;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = word_count;
`ifdef RAM_VERIFY_EN
          verify_err_d = 1'b0;
`endif
          state_d     = (word_count == '0) ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (bus.s_valid && bus.s_ready) begin
          ram_in_d      = bus.s_data;
          ram_address_d = addr;
          state_d       = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Address wraps naturally at 2^ADDR_W.
        addr_d      = addr + 1'b1;
        remaining_d = remaining - 1'b1;
`ifdef RAM_VERIFY_EN
        state_d     = ST_VERIFY;
`else
        state_d     = (remaining == {{ADDR_W{1'b0}}, 1'b1}) ? ST_DONE : ST_ACCEPT;
`endif
      end
      ST_VERIFY: begin
`ifdef RAM_VERIFY_EN
        // RAM captured the word at the end of WRITE; ram_out now reflects the held address.
        if (bus.ram_out != bus.ram_in) verify_err_d = 1'b1;
`endif
        state_d = (remaining == '0) ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d  = (state_d == ST_ACCEPT);
    ram_load_d = (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      addr            <= '0;
      remaining       <= '0;
      bus.s_ready     <= 1'b0;
      bus.ram_load    <= 1'b0;
      bus.ram_address <= '0;
      bus.ram_in      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef RAM_VERIFY_EN
      verify_err_q    <= 1'b0;
`endif
    end else begin
      state           <= state_d;
      addr            <= addr_d;
      remaining       <= remaining_d;
      bus.s_ready     <= s_ready_d;
      bus.ram_load    <= ram_load_d;
      bus.ram_address <= ram_address_d;
      bus.ram_in      <= ram_in_d;
      busy            <= busy_d;
      done            <= done_d;
`ifdef RAM_VERIFY_EN
      verify_err_q    <= verify_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Bench for ram_stream_loader: RAM512 behavioural model as load target,
// expected-write scoreboard popped by a negedge monitor, directed transfers.
// The read-back test runs only when RAM_VERIFY_EN is defined.
module tb_ram_stream_loader;
  import ram_stream_loader_pkg::*;

  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  word_count;
  logic        busy, done, verify_err;

  ram_stream_loader_if bus ();

  ram_stream_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .verify_err (verify_err)
  );

  always #5 clk = ~clk;

  // RAM512 model: synchronous write, combinational read, optional fault injection.
  logic [15:0] mem [512];
  logic        bad_en = 1'b0;
  logic [8:0]  bad_addr = '0;
  assign bus.ram_out = (bad_en && bus.ram_address == bad_addr) ? 16'hDEAD : mem[bus.ram_address];

  always @(posedge clk) begin
    if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
  end

  int  n_cmp = 0;
  int  n_err = 0;
  int  done_cnt = 0;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ram_load pulse must match the next queued write; done pulses are counted.
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (bus.ram_load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {7'd0, bus.ram_address, bus.ram_in}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {23'd0, bus.ram_address}, {23'd0, e.a});
        chk("write_data", {16'd0, bus.ram_in}, {16'd0, e.d});
      end
    end
  end

  task automatic do_start(input logic [8:0] b, input logic [9:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic send_word(input logic [8:0] a, input logic [15:0] d);
    bit ok;
    exp_q.push_back('{a: a, d: d});
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.s_ready) ok = 1'b1;
    end
    chk("handshake", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (done_cnt > d0) ok = 1'b1;
    end
    chk("done_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst_n       = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    word_count  = '0;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h5555;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;

    // T1 reset state, stray s_valid produces nothing
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst_ram_load", {31'd0, bus.ram_load}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_verify_err", {31'd0, verify_err}, 32'd0);
    chk("rst_ram_address", {23'd0, bus.ram_address}, 32'd0);
    chk("rst_ram_in", {16'd0, bus.ram_in}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_ready", {31'd0, bus.s_ready}, 32'd0);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;

    // T2 basic three-word transfer
    d0 = done_cnt;
    do_start(9'h001, 10'd3);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    send_word(9'h001, 16'h00FF);
    send_word(9'h002, 16'hF0F0);
    send_word(9'h003, 16'hAAAA);
    wait_done(d0);
    chk("t2_busy_after", {31'd0, busy}, 32'd0);
    chk("t2_mem1", {16'd0, mem[1]}, 32'h00FF);
    chk("t2_mem2", {16'd0, mem[2]}, 32'hF0F0);
    chk("t2_mem3", {16'd0, mem[3]}, 32'hAAAA);
    chk("t2_hold_addr", {23'd0, bus.ram_address}, 32'h003);
    chk("t2_hold_data", {16'd0, bus.ram_in}, 32'hAAAA);
`ifndef RAM_VERIFY_EN
    chk("t2_verify_err_tied", {31'd0, verify_err}, 32'd0);
`endif

    // T3 address wrap 0x1FF -> 0x000
    d0 = done_cnt;
    do_start(9'h1FF, 10'd2);
    send_word(9'h1FF, 16'h1234);
    send_word(9'h000, 16'h5678);
    wait_done(d0);
    chk("t3_mem1ff", {16'd0, mem[511]}, 32'h1234);
    chk("t3_mem000", {16'd0, mem[0]}, 32'h5678);

    // T4a zero-length transfer: done without any write
    d0 = done_cnt;
    do_start(9'h010, 10'd0);
    wait_done(d0);

    // T4b gapped upstream plus a start while busy
    d0 = done_cnt;
    do_start(9'h020, 10'd2);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        start      = 1'b1;
        base_addr  = 9'h050;
        word_count = 10'd5;
      end
      @(negedge clk);
      chk("t4_gap_ready", {31'd0, bus.s_ready}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    send_word(9'h020, 16'hC001);
    send_word(9'h021, 16'hC002);
    wait_done(d0);
    chk("t4_done_once", done_cnt - d0, 32'd1);

    // T5 reset in the middle of a four-word transfer
    d0 = done_cnt;
    do_start(9'h040, 10'd4);
    send_word(9'h040, 16'h1111);
    send_word(9'h041, 16'h2222);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_load_off", {31'd0, bus.ram_load}, 32'd0);
    chk("t5_busy_off", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_mem41", {16'd0, mem[9'h041]}, 32'h2222);
    d0 = done_cnt;
    do_start(9'h100, 10'd1);
    send_word(9'h100, 16'hBEEF);
    wait_done(d0);
    chk("t5_mem100", {16'd0, mem[9'h100]}, 32'hBEEF);

`ifdef RAM_VERIFY_EN
    // T6 corrupted read-back on the middle word
    bad_addr = 9'h081;
    bad_en   = 1'b1;
    d0 = done_cnt;
    do_start(9'h080, 10'd3);
    chk("t6_err_clear_start", {31'd0, verify_err}, 32'd0);
    send_word(9'h080, 16'h0A0A);
    send_word(9'h081, 16'h0B0B);
    send_word(9'h082, 16'h0C0C);
    wait_done(d0);
    bad_en = 1'b0;
    chk("t6_err_sticky", {31'd0, verify_err}, 32'd1);
    chk("t6_mem82", {16'd0, mem[9'h082]}, 32'h0C0C);
    d0 = done_cnt;
    do_start(9'h090, 10'd0);
    chk("t6_err_cleared", {31'd0, verify_err}, 32'd0);
    wait_done(d0);
`endif

    repeat (3) @(negedge clk);
    chk("writes_outstanding", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
